// File: rtl/semafor_controller.sv
// Intersection sequencer: drives the shared phase bus and the tick strobes
// consumed by the four per-direction light blocks (SUD, NORD, EST, VEST).
//
// Ports:
//   clk, rst             - single clock domain, synchronous active-high reset
//   ready_S/N/E/V        - phase-done pulses from the direction blocks
//   mod_noapte           - night-mode request (level)
//   clr_fault            - one-cycle fault clear
//   stare_semafor [2:0]  - phase bus (000..011 directions, 100 all-red, 111 blink)
//   clk_div              - low for one clk every DIV_TICK clks (tick strobe)
//   clk_div_int          - blink square wave, toggles every BLINK_TICKS ticks
//   fault                - sticky watchdog fault flag
module semafor_controller #(
  parameter int unsigned DIV_TICK      = 50,
  parameter int unsigned BLINK_TICKS   = 1,
  parameter int unsigned CLEAR_TICKS   = 2,
  parameter int unsigned TIMEOUT_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready_S,
  input  logic       ready_N,
  input  logic       ready_E,
  input  logic       ready_V,
  input  logic       mod_noapte,
  input  logic       clr_fault,
  output logic [2:0] stare_semafor,
  output logic       clk_div,
  output logic       clk_div_int,
  output logic       fault
);

  typedef enum logic [2:0] {
    StSud    = 3'b000,
    StNord   = 3'b001,
    StEst    = 3'b010,
    StVest   = 3'b011,
    StAllRed = 3'b100,
    StBlink  = 3'b111
  } state_e;

  localparam int unsigned DivW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int unsigned BlkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned ClrW = (CLEAR_TICKS > 1) ? $clog2(CLEAR_TICKS) : 1;
  localparam int unsigned WdW  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(DIV_TICK - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_TICKS - 1);
  localparam logic [ClrW-1:0] ClrLast = ClrW'(CLEAR_TICKS - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_TICKS - 1);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            fault_q, fault_d;
  logic            blink_q, blink_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
  logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
  logic [WdW-1:0]  wd_cnt_q, wd_cnt_d;
  logic [3:0]      rdy_prev_q, rdy_prev_d;

  logic       tick;
  logic [3:0] rdy;
  logic [3:0] rdy_rise;

  // Bit index matches the direction phase code: S=0, N=1, E=2, V=3.
  assign rdy      = {ready_V, ready_E, ready_N, ready_S};
  assign rdy_rise = rdy & ~rdy_prev_q;

  always_comb begin
    tick       = (div_cnt_q == DivLast);
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    rdy_prev_d = rdy;

    blk_cnt_d = blk_cnt_q;
    blink_d   = blink_q;
    if (tick) begin
      if (blk_cnt_q == BlkLast) begin
        blk_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end

    state_d = state_q;
    ptr_d   = ptr_q;
    fault_d = clr_fault ? 1'b0 : fault_q;

    case (state_q)
      StAllRed: begin
        if (tick && (clr_cnt_q == ClrLast)) begin
          if (mod_noapte || fault_q) state_d = StBlink;
          else                       state_d = state_e'({1'b0, ptr_q});
        end
      end
      StSud, StNord, StEst, StVest: begin
        // Ready edge is checked first so it beats a simultaneous timeout.
        if (rdy_rise[state_q[1:0]]) begin
          state_d = StAllRed;
          ptr_d   = ptr_q + 2'd1;
        end else if (tick && (wd_cnt_q == WdLast)) begin
          state_d = StBlink;
          fault_d = 1'b1;
        end
      end
      StBlink: begin
        if (!mod_noapte && !fault_q) begin
          state_d = StAllRed;
          ptr_d   = 2'd0;
        end
      end
      default: state_d = StAllRed;
    endcase

    // Phase counters only run while their state persists; any transition
    // zeroes them, so a tick coinciding with a transition is not counted.
    clr_cnt_d = '0;
    if (state_q == StAllRed && state_d == StAllRed) begin
      clr_cnt_d = tick ? clr_cnt_q + 1'b1 : clr_cnt_q;
    end
    wd_cnt_d = '0;
    if (!state_q[2] && state_d == state_q) begin
      wd_cnt_d = tick ? wd_cnt_q + 1'b1 : wd_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAllRed;
      ptr_q      <= 2'd0;
      fault_q    <= 1'b0;
      blink_q    <= 1'b0;
      div_cnt_q  <= '0;
      blk_cnt_q  <= '0;
      clr_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      rdy_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      fault_q    <= fault_d;
      blink_q    <= blink_d;
      div_cnt_q  <= div_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      rdy_prev_q <= rdy_prev_d;
    end
  end

  assign stare_semafor = state_q;
  assign clk_div       = ~tick;
  assign clk_div_int   = blink_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_semafor_controller.sv
// Self-checking bench for semafor_controller: directed scenarios followed by
// randomized traffic, every cycle compared against a phase-level reference model.
module tb_semafor_controller;

  localparam int DIV   = 4;
  localparam int BLINK = 1;
  localparam int CLEAR = 2;
  localparam int TMO   = 3;
  localparam int PhAllRed = 4;
  localparam int PhBlink  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready_S = 1'b0, ready_N = 1'b0, ready_E = 1'b0, ready_V = 1'b0;
  logic       mod_noapte = 1'b0;
  logic       clr_fault = 1'b0;
  logic [2:0] stare_semafor;
  logic       clk_div, clk_div_int, fault;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase, next direction, fault, ticks spent in the phase,
  // and absolute clock/tick counts since reset.
  int       m_cyc, m_ticks_total, m_phase, m_ptr, m_cnt;
  bit       m_fault;
  bit [3:0] m_prev;

  semafor_controller #(
    .DIV_TICK(DIV), .BLINK_TICKS(BLINK), .CLEAR_TICKS(CLEAR), .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .ready_S(ready_S), .ready_N(ready_N), .ready_E(ready_E), .ready_V(ready_V),
    .mod_noapte(mod_noapte), .clr_fault(clr_fault),
    .stare_semafor(stare_semafor), .clk_div(clk_div),
    .clk_div_int(clk_div_int), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic bit tick_now();
    return (m_cyc % DIV) == (DIV - 1);
  endfunction

  task automatic model_step();
    bit       tk;
    bit [3:0] rdy;
    bit       nf;
    int       ph;
    if (rst) begin
      m_cyc = 0; m_ticks_total = 0; m_phase = PhAllRed; m_ptr = 0; m_cnt = 0;
      m_fault = 0; m_prev = 4'b0;
      return;
    end
    tk  = tick_now();
    rdy = {ready_V, ready_E, ready_N, ready_S};
    nf  = clr_fault ? 1'b0 : m_fault;
    ph  = m_phase;
    if (ph == PhAllRed) begin
      if (tk) begin
        if (m_cnt + 1 == CLEAR) begin
          m_phase = (mod_noapte || m_fault) ? PhBlink : m_ptr;
          m_cnt   = 0;
        end else m_cnt++;
      end
    end else if (ph == PhBlink) begin
      if (!mod_noapte && !m_fault) begin
        m_phase = PhAllRed; m_ptr = 0; m_cnt = 0;
      end
    end else begin
      if (rdy[ph] && !m_prev[ph]) begin
        m_phase = PhAllRed; m_ptr = (m_ptr + 1) % 4; m_cnt = 0;
      end else if (tk) begin
        if (m_cnt + 1 == TMO) begin
          m_phase = PhBlink; nf = 1'b1; m_cnt = 0;
        end else m_cnt++;
      end
    end
    m_fault = nf;
    m_cyc++;
    if (tk) m_ticks_total++;
    m_prev = rdy;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("stare", {5'b0, stare_semafor}, 8'(m_phase));
    chk("clk_div", {7'b0, clk_div}, {7'b0, !tick_now()});
    chk("clk_div_int", {7'b0, clk_div_int}, 8'((m_ticks_total / BLINK) % 2));
    chk("fault", {7'b0, fault}, {7'b0, m_fault});
  endtask

  task automatic wait_phase(input string tag, input int exp);
    int n = 0;
    while (stare_semafor !== exp[2:0] && n < 60) begin
      cyc();
      n++;
    end
    chk(tag, {5'b0, stare_semafor}, 8'(exp));
  endtask

  task automatic set_ready(input int idx, input logic v);
    case (idx)
      0: ready_S = v;
      1: ready_N = v;
      2: ready_E = v;
      default: ready_V = v;
    endcase
  endtask

  task automatic pulse_ready(input int idx);
    set_ready(idx, 1'b1);
    cyc();
    set_ready(idx, 1'b0);
    chk("adv_to_allred", {5'b0, stare_semafor}, 8'(PhAllRed));
  endtask

  initial begin
    logic v;
    int   n;
    // Reset and idle
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_stare", {5'b0, stare_semafor}, 8'(PhAllRed));
    chk("rst_clk_div", {7'b0, clk_div}, 8'd1);
    chk("rst_clk_div_int", {7'b0, clk_div_int}, 8'd0);
    chk("rst_fault", {7'b0, fault}, 8'd0);
    repeat (3) cyc();
    chk("clk_div_low_4th", {7'b0, clk_div}, 8'd0);
    repeat (4) cyc();
    chk("still_allred", {5'b0, stare_semafor}, 8'(PhAllRed));
    cyc();
    chk("sud_after_2_ticks", {5'b0, stare_semafor}, 8'd0);

    // Normal cycle
    for (int d = 0; d < 4; d++) begin
      pulse_ready(d);
      wait_phase("normal_next", (d + 1) % 4);
      chk("normal_fault", {7'b0, fault}, 8'd0);
    end

    // Wrong-direction ready, then a held ready advances once
    pulse_ready_wrong: begin
      ready_E = 1'b1;
      cyc();
      ready_E = 1'b0;
      cyc();
      chk("wrong_dir_ignored", {5'b0, stare_semafor}, 8'd0);
    end
    ready_S = 1'b1;
    repeat (5) cyc();
    ready_S = 1'b0;
    wait_phase("held_ready_one_adv", 1);
    cyc();
    chk("held_no_second_adv", {5'b0, stare_semafor}, 8'd1);

    // Watchdog in NORD
    wait_phase("watchdog_blink", PhBlink);
    chk("watchdog_fault", {7'b0, fault}, 8'd1);
    repeat (3) cyc();
    chk("fault_sticky", {5'b0, stare_semafor}, 8'(PhBlink));
    clr_fault = 1'b1;
    cyc();
    clr_fault = 1'b0;
    chk("clr_fault", {7'b0, fault}, 8'd0);
    cyc();
    chk("clr_to_allred", {5'b0, stare_semafor}, 8'(PhAllRed));
    wait_phase("clr_then_sud", 0);

    // Night mode
    pulse_ready(0);
    wait_phase("night_pre_n", 1);
    pulse_ready(1);
    wait_phase("night_pre_e", 2);
    mod_noapte = 1'b1;
    repeat (2) cyc();
    chk("night_holds_est", {5'b0, stare_semafor}, 8'd2);
    pulse_ready(2);
    wait_phase("night_blink", PhBlink);
    v = clk_div_int;
    repeat (DIV) cyc();
    chk("blink_toggle_1", {7'b0, clk_div_int}, {7'b0, ~v});
    repeat (DIV) cyc();
    chk("blink_toggle_2", {7'b0, clk_div_int}, {7'b0, v});
    mod_noapte = 1'b0;
    cyc();
    chk("night_off_allred", {5'b0, stare_semafor}, 8'(PhAllRed));
    wait_phase("night_off_sud", 0);

    // Ready edge coinciding with watchdog expiry in NORD
    pulse_ready(0);
    wait_phase("coll_nord", 1);
    n = 0;
    while (!(m_phase == 1 && m_cnt == TMO - 1 && tick_now()) && n < 60) begin
      cyc();
      n++;
    end
    chk("coll_aligned", {7'b0, (n < 60)}, 8'd1);
    ready_N = 1'b1;
    cyc();
    ready_N = 1'b0;
    chk("coll_allred", {5'b0, stare_semafor}, 8'(PhAllRed));
    chk("coll_no_fault", {7'b0, fault}, 8'd0);

    // Reset during VEST
    wait_phase("to_est", 2);
    pulse_ready(2);
    wait_phase("to_vest", 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_stare", {5'b0, stare_semafor}, 8'(PhAllRed));
    chk("rst_mid_clk_div", {7'b0, clk_div}, 8'd1);
    chk("rst_mid_clk_div_int", {7'b0, clk_div_int}, 8'd0);
    chk("rst_mid_fault", {7'b0, fault}, 8'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      ready_S    = ($urandom_range(9, 0) == 0);
      ready_N    = ($urandom_range(9, 0) == 0);
      ready_E    = ($urandom_range(9, 0) == 0);
      ready_V    = ($urandom_range(9, 0) == 0);
      clr_fault  = ($urandom_range(29, 0) == 0);
      rst        = ($urandom_range(299, 0) == 0);
      if ($urandom_range(49, 0) == 0) mod_noapte = ~mod_noapte;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
